// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake fabric: default constant, counter width and the
// occupancy encoding of the two-entry elastic buffers.
package handshake_pkg;

  localparam logic [31:0] DefaultConst    = 32'h0001E951;
  localparam int unsigned DefaultCntWidth = 16;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccFull  = 2'd2
  } occ_e;

endpackage

// File: rtl/handshake_const_match_if.sv
// Valid/ready data input channel and 1-bit result output channel of handshake_const_match.
interface handshake_const_match_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic                  outs;
  logic                  outs_valid;
  logic                  outs_ready;

  // Environment side: produces data tokens and consumes match tokens.
  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/handshake_fifo2.sv
// Generic two-entry elastic FIFO. Both ready and valid are pure functions of the
// registered occupancy, so neither channel sees a combinational path from the other.
module handshake_fifo2
  import handshake_pkg::*;
#(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  occ_e             occ_q, occ_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic             push, pop;

  assign in_ready  = (occ_q != OccFull);
  assign out_valid = (occ_q != OccEmpty);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OccEmpty: begin
        if (push) begin
          occ_d  = OccOne;
          head_d = in_data;
        end
      end
      OccOne: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          occ_d  = OccFull;
          tail_d = in_data;
        end else if (pop) begin
          occ_d = OccEmpty;
        end
      end
      OccFull: begin
        if (pop) begin
          occ_d  = OccOne;
          head_d = tail_q;
        end
      end
      default: occ_d = OccEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= OccEmpty;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/handshake_const_match.sv
// Compares each accepted token with CONST_VALUE and emits a 1-bit match token through a
// two-entry elastic buffer. Statistics are built only when HANDSHAKE_MATCH_STATS_EN is defined.
module handshake_const_match
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] CONST_VALUE = DefaultConst,
  parameter int unsigned CNT_WIDTH   = DefaultCntWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  handshake_const_match_if.slave bus,
  input  logic                  stats_clr,
  output logic [CNT_WIDTH-1:0]  tok_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic                  miss_seen
);

  // Zero-extends or truncates the constant to the data width.
  localparam logic [DATA_WIDTH-1:0] ConstCmp = DATA_WIDTH'(CONST_VALUE);

  logic match;
  logic accept;

  assign match  = (bus.ins == ConstCmp);
  assign accept = bus.ins_valid & bus.ins_ready;

  handshake_fifo2 #(
    .Width (1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (match),
    .in_valid  (bus.ins_valid),
    .in_ready  (bus.ins_ready),
    .out_data  (bus.outs),
    .out_valid (bus.outs_valid),
    .out_ready (bus.outs_ready)
  );

`ifdef HANDSHAKE_MATCH_STATS_EN
  logic [CNT_WIDTH-1:0] tok_q, tok_d;
  logic [CNT_WIDTH-1:0] miss_q, miss_d;
  logic                 seen_q, seen_d;

  // Clear takes priority over a same-cycle accept; counters stick at all-ones.
  always_comb begin
    tok_d  = tok_q;
    miss_d = miss_q;
    seen_d = seen_q;
    if (stats_clr) begin
      tok_d  = '0;
      miss_d = '0;
      seen_d = 1'b0;
    end else if (accept) begin
      if (tok_q != '1) tok_d = tok_q + CNT_WIDTH'(1);
      if (!match) begin
        if (miss_q != '1) miss_d = miss_q + CNT_WIDTH'(1);
        seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok_q  <= '0;
      miss_q <= '0;
      seen_q <= 1'b0;
    end else begin
      tok_q  <= tok_d;
      miss_q <= miss_d;
      seen_q <= seen_d;
    end
  end

  assign tok_cnt   = tok_q;
  assign miss_cnt  = miss_q;
  assign miss_seen = seen_q;
`else
  logic unused_stats;
  assign unused_stats = stats_clr ^ accept;
  assign tok_cnt      = '0;
  assign miss_cnt     = '0;
  assign miss_seen    = 1'b0;
`endif

endmodule
